// File: rtl/eth_wrr_sched.sv
// Frame-level weighted round-robin scheduler for the shared Ethernet transmit path.
// A grant is locked for a whole frame and released on the granted port's tlast
// handshake. Each port may send max(weight,1) consecutive frames per round.
`timescale 1ns/1ps

module eth_wrr_sched #(
    parameter int S_COUNT      = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CL_S_COUNT   = $clog2(S_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic [S_COUNT-1:0]                request,
    input  logic [S_COUNT-1:0]                acknowledge,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   weight,
    output logic [S_COUNT-1:0]                grant,
    output logic                              grant_valid,
    output logic [CL_S_COUNT-1:0]             grant_encoded
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // A programmed weight of 0 still allows one frame per round.
    function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
        return (w == '0) ? WEIGHT_WIDTH'(1) : w;
    endfunction

    logic [0:0]              state;
    logic [CL_S_COUNT-1:0]   pointer;
    logic [WEIGHT_WIDTH-1:0] credit     [S_COUNT];
    logic [WEIGHT_WIDTH-1:0] eff_credit [S_COUNT];
    logic [S_COUNT-1:0]      eligible;
    logic [S_COUNT-1:0]      candidate;
    logic                    reload;
    logic                    found;
    logic [CL_S_COUNT-1:0]   sel;
    logic [CL_S_COUNT:0]     scan_sum;
    logic [CL_S_COUNT-1:0]   scan_idx;
    logic [WEIGHT_WIDTH-1:0] sel_credit_next;
    logic [CL_S_COUNT-1:0]   pointer_next;

    // Per-port eligibility on stored credits (used only to decide a reload).
    genvar g;
    generate
        for (g = 0; g < S_COUNT; g++) begin : g_port
            assign eligible[g]   = request[g] && (credit[g] != '0);
            assign eff_credit[g] = reload ? eff_weight(weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH])
                                          : credit[g];
            assign candidate[g]  = request[g] && (eff_credit[g] != '0);
        end
    endgenerate

    // A new round starts in the same cycle that every requester has run out of credit.
    assign reload = (state == ST_IDLE) && enable && (request != '0) && (eligible == '0);

    // Round-robin search upward from the pointer, wrapping modulo S_COUNT.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            scan_sum = {1'b0, pointer} + (CL_S_COUNT+1)'(k);
            if (scan_sum >= (CL_S_COUNT+1)'(S_COUNT)) begin
                scan_sum = scan_sum - (CL_S_COUNT+1)'(S_COUNT);
            end
            scan_idx = scan_sum[CL_S_COUNT-1:0];
            if (!found && candidate[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    // Credit left to the winner and where the pointer goes next.
    always_comb begin
        sel_credit_next = eff_credit[sel] - WEIGHT_WIDTH'(1);
        if (sel_credit_next != '0) begin
            pointer_next = sel;
        end else if (sel == CL_S_COUNT'(S_COUNT-1)) begin
            pointer_next = '0;
        end else begin
            pointer_next = sel + CL_S_COUNT'(1);
        end
    end

    // Grant state machine: issue in IDLE, hold for the frame, release on the owner's ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            pointer       <= '0;
            for (int i = 0; i < S_COUNT; i++) begin
                credit[i] <= '0;
            end
        end else if (state == ST_IDLE) begin
            if (enable && found) begin
                state         <= ST_GRANT;
                grant         <= S_COUNT'(1) << sel;
                grant_valid   <= 1'b1;
                grant_encoded <= sel;
                pointer       <= pointer_next;
                for (int i = 0; i < S_COUNT; i++) begin
                    credit[i] <= (CL_S_COUNT'(i) == sel) ? sel_credit_next : eff_credit[i];
                end
            end
        end else begin
            if ((acknowledge & grant) != '0) begin
                state       <= ST_IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_wrr_sched.sv
// Bench for eth_wrr_sched: directed scenarios plus randomized traffic, all
// compared against a frame-level reference model of the scheduler.
`timescale 1ns/1ps

module tb_eth_wrr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  request = '0;
    logic [3:0]  acknowledge = '0;
    logic [15:0] weight = '0;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_encoded;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_credit [4];
    int m_ptr;
    int m_enc;
    int m_gv;

    // observation helpers
    int   seq [$];
    int   gaps [$];
    int   idle_run;
    int   age;
    logic prev_gv;

    eth_wrr_sched #(.S_COUNT(4), .WEIGHT_WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .request       (request),
        .acknowledge   (acknowledge),
        .weight        (weight),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_credit[p] = 0;
        m_ptr = 0; m_enc = 0; m_gv = 0;
        seq.delete(); gaps.delete();
        idle_run = 0; age = 0; prev_gv = 1'b0;
    endtask

    // One clock of the scheduler, described frame by frame with plain integers.
    task automatic model_step(input logic en, input logic [3:0] req, input logic [3:0] ack);
        int any, w, pick, p;
        if (m_gv != 0) begin
            if (ack[m_enc[1:0]]) m_gv = 0;
        end else if (en && req != 4'b0) begin
            any = 0;
            for (int q = 0; q < 4; q++) if (req[q[1:0]] && m_credit[q] > 0) any = 1;
            if (any == 0) begin
                for (int q = 0; q < 4; q++) begin
                    w = int'(weight[q*4 +: 4]);
                    m_credit[q] = (w == 0) ? 1 : w;
                end
            end
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                p = (m_ptr + k) % 4;
                if (pick < 0 && req[p[1:0]] && m_credit[p] > 0) pick = p;
            end
            m_credit[pick] = m_credit[pick] - 1;
            m_enc = pick;
            m_gv  = 1;
            m_ptr = (m_credit[pick] > 0) ? pick : (pick + 1) % 4;
        end
    endtask

    function automatic logic [3:0] model_grant();
        return (m_gv != 0) ? 4'(1 << m_enc) : 4'b0;
    endfunction

    // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
    task automatic cycle(input logic en, input logic [3:0] req, input logic [3:0] ack);
        enable = en; request = req; acknowledge = ack;
        model_step(en, req, ack);
        @(posedge clk);
        @(negedge clk);
        check("grant", 32'(grant), 32'(model_grant()));
        check("grant_valid", 32'(grant_valid), 32'(m_gv != 0));
        check("grant_encoded", 32'(grant_encoded), 32'(m_enc));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        if (grant_valid && !prev_gv) begin
            seq.push_back(int'(grant_encoded));
            gaps.push_back(idle_run);
        end
        idle_run = grant_valid ? 0 : idle_run + 1;
        prev_gv  = grant_valid;
        age      = (m_gv != 0) ? age + 1 : 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; request = '0; acknowledge = '0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_gv", 32'(grant_valid), 32'd0);
        check("rst_enc", 32'(grant_encoded), 32'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] auto_ack(input int hold);
        return (m_gv != 0 && age >= hold) ? 4'(1 << m_enc) : 4'b0;
    endfunction

    initial begin
        int exp1 [6];
        int exp2 [12];
        exp1 = '{0, 1, 2, 3, 0, 1};
        exp2 = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
        model_reset();

        // all weights 1, every frame acked after three cycles
        weight = 16'h1111;
        do_reset();
        for (int c = 0; c < 30; c++) cycle(1'b1, 4'b1111, auto_ack(3));
        check("t1_count", 32'(seq.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            check("t1_seq", 32'(seq[i]), 32'(exp1[i]));
            if (i > 0) check("t1_gap", 32'(gaps[i]), 32'd1);
        end

        // weights p0=3 p1=1 p2=0 p3=1
        weight = 16'h1013;
        do_reset();
        for (int c = 0; c < 60; c++) cycle(1'b1, 4'b1111, auto_ack(2));
        check("t2_count", 32'(seq.size() >= 12), 32'd1);
        for (int i = 0; i < 12 && i < seq.size(); i++) check("t2_seq", 32'(seq[i]), 32'(exp2[i]));

        // only p2 requests; request drops and a foreign ack arrives mid-frame
        weight = 16'h0200;
        do_reset();
        cycle(1'b1, 4'b0100, 4'b0000);
        check("t3_grant", 32'(grant), 32'h4);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 4'b0000, 4'b0010);
            check("t3_hold", 32'(grant), 32'h4);
        end
        cycle(1'b1, 4'b0000, 4'b0100);
        check("t3_release", 32'(grant), 32'h0);

        // enable gating
        weight = 16'h1111;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 4'b0011, 4'b0000);
            check("t4_off", 32'(grant), 32'h0);
        end
        cycle(1'b1, 4'b0011, 4'b0000);
        check("t4_on", 32'(grant), 32'h1);
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 4'b0011, 4'b0000);
            check("t4_held", 32'(grant), 32'h1);
        end
        cycle(1'b0, 4'b0011, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 4'b0011, 4'b0000);
            check("t4_nonew", 32'(grant), 32'h0);
        end

        // credit skip: p0 spent, p1 has credit, pointer back at 0
        weight = 16'h1121;
        do_reset();
        cycle(1'b1, 4'b1001, 4'b0000);
        check("t5_p0", 32'(grant), 32'h1);
        cycle(1'b1, 4'b0000, 4'b0001);
        cycle(1'b1, 4'b1000, 4'b0000);
        check("t5_p3", 32'(grant), 32'h8);
        cycle(1'b1, 4'b0000, 4'b1000);
        cycle(1'b1, 4'b0011, 4'b0000);
        check("t5_skip", 32'(grant), 32'h2);
        cycle(1'b1, 4'b0000, 4'b0010);
        cycle(1'b1, 4'b0011, 4'b0000);
        check("t5_again", 32'(grant), 32'h2);
        cycle(1'b1, 4'b0000, 4'b0010);
        cycle(1'b1, 4'b0011, 4'b0000);
        check("t5_reload", 32'(grant), 32'h1);

        // asynchronous reset in the middle of a frame
        weight = 16'h1111;
        do_reset();
        cycle(1'b1, 4'b1000, 4'b0000);
        check("t6_grant", 32'(grant), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'h0);
        check("t6_async_gv", 32'(grant_valid), 32'h0);
        check("t6_async_enc", 32'(grant_encoded), 32'h0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle(1'b1, 4'b1000, 4'b0000);
        check("t6_regrant", 32'(grant), 32'h8);

        // randomized traffic with occasional weight changes
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] rq, ak;
            logic en;
            if (c % 200 == 0) weight = 16'($urandom);
            en = ($urandom_range(0, 9) != 0);
            rq = 4'($urandom);
            ak = 4'($urandom) & 4'($urandom);
            if (m_gv != 0 && $urandom_range(0, 3) == 0) ak = ak | 4'(1 << m_enc);
            cycle(en, rq, ak);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_wrr_sched.md
Name: eth_wrr_sched

Overview:
- Frame-level weighted round-robin scheduler that decides which Ethernet frame source is granted the shared transmit path.
- Sits in front of the arbitrated Ethernet mux datapath and produces the grant, grant_valid and grant_encoded signals that steer header and payload selection.
- Grant is locked for a whole frame and released only on the granted port's tlast handshake.
- Per-port weights set how many consecutive frames a port may send per round.

Parameters:
- S_COUNT, 4, number of requesting source ports (2..16).
- WEIGHT_WIDTH, 4, width of each per-port weight and credit counter.
- CL_S_COUNT, $clog2(S_COUNT), width of grant_encoded (derived; not to be overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  when low, no new grant is issued; a grant already issued still completes normally.
- request  input  S_COUNT  per-port frame pending (header valid, masked with ~grant by the user).
- acknowledge  input  S_COUNT  per-port end of frame: tvalid & tready & tlast of that port.
- weight  input  S_COUNT*WEIGHT_WIDTH  frames per round for each port; port i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 is treated as 1.
- grant  output  S_COUNT  one-hot grant, registered.
- grant_valid  output  1  high when grant != 0, registered.
- grant_encoded  output  CL_S_COUNT  index of the granted port; holds its last value while grant_valid is low.

Behaviour:
- Reset: grant=0, grant_valid=0, grant_encoded=0, state=IDLE, pointer=0, all credits=0.
- Two states: IDLE and GRANT.
- Credits: one WEIGHT_WIDTH counter per port.
  - eligible = request & (credit != 0).
  - Reload condition (IDLE only): enable=1, request != 0 and eligible == 0.
  - On reload, every port's effective credit for that cycle = max(weight,1), and the credit registers load that value, minus the one credit consumed by any port granted in the same cycle.
  - Arbitration runs in that same cycle on the reloaded credits, so a reload adds no bubble.
- IDLE, with enable=1 and at least one candidate:
  - Select the first candidate found searching upward from pointer, wrapping modulo S_COUNT.
  - Next cycle: grant=onehot(i), grant_valid=1, grant_encoded=i, state=GRANT, credit[i] decremented by 1.
  - Pointer update: if the decremented credit[i] != 0, pointer stays at i (the port keeps priority for consecutive frames). Otherwise pointer = i+1, wrapping to 0 after S_COUNT-1.
- IDLE, with enable=0 or request=0: outputs and credits unchanged.
- GRANT:
  - Grant is held unchanged regardless of request or enable changes (frame lock).
  - acknowledge on non-granted ports is ignored.
  - acknowledge[grant_encoded]=1 at cycle M: grant=0 and grant_valid=0 at M+1, state=IDLE. The earliest next grant is at M+2, a fixed one-cycle bubble.
- Latency: request seen in IDLE at cycle N -> grant visible at N+1.
- Simultaneous events:
  - A request asserting on the same cycle as an ack is evaluated in the following IDLE cycle.
  - A weight change takes effect only at the next reload.
  - A port whose credit is 0 is skipped even if it has the highest pointer priority, while any other port is still eligible.
- Widths: credit decrement never wraps, because a grant requires credit >= 1. grant is always zero or one-hot.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); no frame completion is tracked across reset.

Test Plan:
- S_COUNT=4, weights all 1, request=4'b1111 held, each grant acked after 3 cycles -> grant_encoded sequence 0,1,2,3,0,1; exactly one idle cycle between grants; the reload occurs in the IDLE cycle before the 5th grant.
- weights {p0=3,p1=1,p2=0,p3=1}, all requesting -> sequence 0,0,0,1,2,3 then repeats; weight 0 behaves as 1.
- Only p2 requests, weight=2, request drops mid-frame -> grant stays 4'b0100 until acknowledge[2]; ack on p1 during the frame has no effect.
- enable=0 with request=4'b0011 -> no grant. enable 0->1 at cycle K -> grant=4'b0001 at K+1. Drop enable mid-frame -> grant held until ack, then no new grant.
- Credit skip: p0 weight 1 already spent, p1 weight 2 with credit left, pointer=0, both requesting -> p1 granted and no reload occurs.
- rst_n pulled low while grant=4'b1000 -> grant, grant_valid and grant_encoded are 0 immediately. After release with request=4'b1000 -> grant returns one cycle after the first active edge, with credits reloaded.
